genie_wrr_sched: RTL and testbench

- Weighted round-robin packet scheduler for an NI-input merge datapath.
- Computes the mux select and per-input readies so that whole packets are never interleaved.
- Each input may send up to a configurable number of consecutive packets (its weight) before the grant rotates.
- Sits beside an external data/eop mux. That mux is driven by o_sel, and its output handshake is closed through i_ready.

---
 rtl/genie_wrr_sched.sv | 199 +++++++++++++++++++
 tb/tb_genie_wrr_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/genie_wrr_sched.sv
// genie_wrr_sched: weighted round-robin packet scheduler for an NI-input merge.
// Drives the select of an external data/eop mux and the per-input readies so that
// packets are never interleaved. An input may send up to its weight in back-to-back
// packets before the grant rotates to the next eligible input.
module genie_wrr_sched #(
  parameter int NI             = 4,
  parameter int WBITS          = 4,
  parameter int DEFAULT_WEIGHT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NI-1:0]         i_valid,
  input  logic [NI-1:0]         i_eop,
  output logic [NI-1:0]         o_ready,
  input  logic                  i_ready,
  output logic [$clog2(NI)-1:0] o_sel,
  output logic                  o_valid,
  input  logic [NI*WBITS-1:0]   cfg_weight,
  input  logic                  cfg_load
);

  localparam int SW = $clog2(NI);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCKED = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SW-1:0]    cur;
  logic [SW-1:0]    cur_nxt;
  logic [SW-1:0]    last_grant;
  logic [SW-1:0]    last_nxt;

  logic [WBITS-1:0] weight     [NI];
  logic [WBITS-1:0] credit     [NI];
  logic [WBITS-1:0] credit_nxt [NI];
  logic [WBITS-1:0] new_weight [NI];
  logic [WBITS-1:0] eff_weight [NI];

  logic [NI-1:0]    eligible;
  logic             rr_found;
  logic [SW-1:0]    rr_pick;
  logic [SW-1:0]    sel;
  logic             sel_valid;
  logic             grant_active;
  logic             accept;
  logic             end_pkt;
  logic             release_hold;

  // Unpack the weight bus, pick the weight a reload would use this cycle, and mask inputs.
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      new_weight[i] = cfg_weight[i*WBITS +: WBITS];
      eff_weight[i] = cfg_load ? new_weight[i] : weight[i];
      eligible[i]   = i_valid[i] && (weight[i] != '0);
    end
  end

  // Round-robin search starting just after the last input that finished its turn.
  always_comb begin
    logic [SW-1:0] idx;
    idx      = '0;
    rr_found = 1'b0;
    rr_pick  = last_grant;
    for (int k = 1; k <= NI; k++) begin
      idx = SW'((int'(last_grant) + k) % NI);
      if (!rr_found && eligible[idx]) begin
        rr_found = 1'b1;
        rr_pick  = idx;
      end
    end
  end

  // Select and grant: free arbitration when idle, pinned to cur while locked or holding.
  always_comb begin
    sel          = last_grant;
    sel_valid    = 1'b0;
    grant_active = 1'b0;
    case (state)
      S_IDLE: begin
        sel          = rr_pick;
        grant_active = rr_found;
        sel_valid    = rr_found;
      end
      S_LOCKED: begin
        sel          = cur;
        grant_active = 1'b1;
        sel_valid    = i_valid[cur];
      end
      S_HOLD: begin
        sel          = cur;
        grant_active = eligible[cur];
        sel_valid    = eligible[cur];
      end
      default: begin
        sel = last_grant;
      end
    endcase
  end

  assign accept = sel_valid && i_ready;

  // Output drive, forced quiet while reset is asserted.
  always_comb begin
    o_sel   = reset_n ? sel : '0;
    o_valid = reset_n && sel_valid;
    for (int i = 0; i < NI; i++) begin
      o_ready[i] = reset_n && i_ready && grant_active && (sel == SW'(i));
    end
  end

  // Next state, grant bookkeeping and credit accounting; a stalled i_ready freezes everything.
  always_comb begin
    state_nxt    = state;
    cur_nxt      = cur;
    last_nxt     = last_grant;
    end_pkt      = 1'b0;
    release_hold = 1'b0;
    for (int i = 0; i < NI; i++) begin
      credit_nxt[i] = credit[i];
    end

    case (state)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          if (i_eop[sel]) begin
            end_pkt = 1'b1;
          end else begin
            cur_nxt   = sel;
            state_nxt = S_LOCKED;
          end
        end else if ((state == S_HOLD) && !grant_active && i_ready) begin
          release_hold = 1'b1;
        end
      end
      S_LOCKED: begin
        if (accept && i_eop[cur]) begin
          end_pkt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (end_pkt) begin
      if (credit[sel] > WBITS'(1)) begin
        credit_nxt[sel] = credit[sel] - WBITS'(1);
        cur_nxt         = sel;
        state_nxt       = S_HOLD;
      end else begin
        credit_nxt[sel] = eff_weight[sel];
        last_nxt        = sel;
        state_nxt       = S_IDLE;
      end
    end

    if (release_hold) begin
      credit_nxt[cur] = eff_weight[cur];
      last_nxt        = cur;
      state_nxt       = S_IDLE;
    end

    if (cfg_load) begin
      for (int i = 0; i < NI; i++) begin
        if (credit_nxt[i] > new_weight[i]) begin
          credit_nxt[i] = new_weight[i];
        end
      end
    end
  end

  // State, grant history, weights and credits; reset gives input 0 first priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cur        <= '0;
      last_grant <= SW'(NI - 1);
      for (int i = 0; i < NI; i++) begin
        weight[i] <= WBITS'(DEFAULT_WEIGHT);
        credit[i] <= WBITS'(DEFAULT_WEIGHT);
      end
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      last_grant <= last_nxt;
      for (int i = 0; i < NI; i++) begin
        credit[i] <= credit_nxt[i];
        if (cfg_load) begin
          weight[i] <= new_weight[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_genie_wrr_sched.sv
// tb_genie_wrr_sched: directed scenarios with literal grant sequences, then a random
// phase, all shadowed every cycle by a packet-level reference model of the scheduler.
module tb_genie_wrr_sched;

  localparam int NI    = 4;
  localparam int WBITS = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NI-1:0]       i_valid;
  logic [NI-1:0]       i_eop;
  logic [NI-1:0]       o_ready;
  logic                i_ready;
  logic [1:0]          o_sel;
  logic                o_valid;
  logic [NI*WBITS-1:0] cfg_weight;
  logic                cfg_load;

  int compared   = 0;
  int mismatched = 0;

  int            m_last;
  int            m_owner;
  bit            m_mid;
  int            m_weight [NI];
  int            m_credit [NI];
  int            exp_sel;
  bit            exp_valid;
  bit            exp_grant;
  logic [NI-1:0] exp_ready;

  genie_wrr_sched #(.NI(NI), .WBITS(WBITS), .DEFAULT_WEIGHT(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_valid    (i_valid),
    .i_eop      (i_eop),
    .o_ready    (o_ready),
    .i_ready    (i_ready),
    .o_sel      (o_sel),
    .o_valid    (o_valid),
    .cfg_weight (cfg_weight),
    .cfg_load   (cfg_load)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic logic [NI*WBITS-1:0] packW(input int w0, input int w1, input int w2, input int w3);
    return {4'(w3), 4'(w2), 4'(w1), 4'(w0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_last  = NI - 1;
    m_owner = -1;
    m_mid   = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_weight[i] = 1;
      m_credit[i] = 1;
    end
  endtask

  task automatic modelExpect();
    exp_sel   = m_last;
    exp_valid = 1'b0;
    exp_grant = 1'b0;
    if (!reset_n) begin
      exp_sel = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NI; k++) begin
        int c;
        c = (m_last + k) % NI;
        if (i_valid[c] && m_weight[c] != 0) begin
          exp_sel   = c;
          exp_grant = 1'b1;
          exp_valid = 1'b1;
          break;
        end
      end
    end else if (m_mid) begin
      exp_sel   = m_owner;
      exp_grant = 1'b1;
      exp_valid = i_valid[m_owner];
    end else begin
      exp_sel   = m_owner;
      exp_grant = i_valid[m_owner] && (m_weight[m_owner] != 0);
      exp_valid = exp_grant;
    end
    exp_ready = (reset_n && exp_grant && i_ready) ? 4'(1 << exp_sel) : 4'b0000;
  endtask

  task automatic modelAdvance();
    int nw [NI];
    int g;
    if (!reset_n) begin
      modelReset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      nw[i] = cfg_load ? int'(cfg_weight[i*WBITS +: WBITS]) : m_weight[i];
    end
    if (exp_valid && i_ready) begin
      g = exp_sel;
      if (i_eop[g]) begin
        if (m_credit[g] > 1) begin
          m_credit[g] = m_credit[g] - 1;
          m_owner     = g;
          m_mid       = 1'b0;
        end else begin
          m_credit[g] = nw[g];
          m_last      = g;
          m_owner     = -1;
          m_mid       = 1'b0;
        end
      end else begin
        m_owner = g;
        m_mid   = 1'b1;
      end
    end else if (m_owner >= 0 && !m_mid && !exp_grant && i_ready) begin
      m_credit[m_owner] = nw[m_owner];
      m_last            = m_owner;
      m_owner           = -1;
    end
    if (cfg_load) begin
      for (int i = 0; i < NI; i++) begin
        m_weight[i] = nw[i];
        if (m_credit[i] > nw[i]) m_credit[i] = nw[i];
      end
    end
  endtask

  task automatic applyStimulus(input logic [NI-1:0] valid, input logic [NI-1:0] eop, input logic ready,
                               input logic load, input logic [NI*WBITS-1:0] wts, input bit rst_low);
    @(negedge clk);
    reset_n    = !rst_low;
    i_valid    = valid;
    i_eop      = eop;
    i_ready    = ready;
    cfg_load   = load;
    cfg_weight = wts;
    #1;
    modelExpect();
    checkOutput("model_sel", 32'(o_sel), 32'(exp_sel));
    checkOutput("model_valid", 32'(o_valid), 32'(exp_valid));
    checkOutput("model_ready", 32'(o_ready), 32'(exp_ready));
    modelAdvance();
  endtask

  // Directed scenarios followed by randomized traffic, then the summary.
  initial begin
    int               seq2 [10];
    int               seq4 [5];
    logic             rdy3 [6];
    logic             eop3 [6];
    logic [NI-1:0]    v5   [11];
    int               s5   [11];
    logic             ov5  [11];
    logic [NI-1:0]    rv;
    logic [NI-1:0]    re;
    logic [NI*WBITS-1:0] rw;

    seq2 = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    seq4 = '{1, 0, 1, 1, 0};
    rdy3 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    eop3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    v5   = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0100,
             4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
    s5   = '{0, 2, 0, 0, 0, 2, 0, 0, 0, 0, 2};
    ov5  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    reset_n    = 1'b0;
    i_valid    = '0;
    i_eop      = '0;
    i_ready    = 1'b0;
    cfg_load   = 1'b0;
    cfg_weight = '0;
    modelReset();

    $display("[TB] reset with all inputs valid");
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("reset_sel", 32'(o_sel), 0);
    checkOutput("reset_valid", 32'(o_valid), 0);
    checkOutput("reset_ready", 32'(o_ready), 0);

    $display("[TB] equal weights, single-beat packets");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("t1_order", 32'(o_sel), 32'(k % 4));
      checkOutput("t1_valid", 32'(o_valid), 1);
    end

    $display("[TB] weight 3 on input 0");
    applyStimulus('0, '0, 1'b1, 1'b0, '0, 1'b1);
    applyStimulus('0, '0, 1'b1, 1'b1, packW(3, 1, 1, 1), 1'b0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b0011, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("t2_order", 32'(o_sel), 32'(seq2[k]));
    end

    $display("[TB] multi-beat packet with stalls");
    applyStimulus('0, '0, 1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b1100, {1'b1, eop3[k], 2'b00}, rdy3[k], 1'b0, '0, 1'b0);
      checkOutput("t3_sel", 32'(o_sel), 2);
      checkOutput("t3_ready3", 32'(o_ready[3]), 0);
      checkOutput("t3_ready2", 32'(o_ready[2]), 32'(rdy3[k]));
    end
    applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("t3_next", 32'(o_sel), 3);

    $display("[TB] masking input 1 with weight 0, then weight 2");
    applyStimulus('0, '0, 1'b1, 1'b0, '0, 1'b1);
    applyStimulus(4'b0011, 4'b1111, 1'b1, 1'b1, packW(1, 0, 1, 1), 1'b0);
    checkOutput("t4_load_sel", 32'(o_sel), 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0011, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("t4_masked_sel", 32'(o_sel), 0);
      checkOutput("t4_masked_ready1", 32'(o_ready[1]), 0);
    end
    applyStimulus(4'b0011, 4'b1111, 1'b1, 1'b1, packW(1, 2, 1, 1), 1'b0);
    checkOutput("t4_reload_sel", 32'(o_sel), 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0011, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("t4_order", 32'(o_sel), 32'(seq4[k]));
    end

    $display("[TB] hold bubble when input 0 drops valid");
    applyStimulus('0, '0, 1'b1, 1'b0, '0, 1'b1);
    applyStimulus('0, '0, 1'b1, 1'b1, packW(4, 1, 1, 1), 1'b0);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(v5[k], 4'b1111, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("t5_sel", 32'(o_sel), 32'(s5[k]));
      checkOutput("t5_valid", 32'(o_valid), 32'(ov5[k]));
    end

    $display("[TB] reset in the middle of a locked packet");
    applyStimulus('0, '0, 1'b1, 1'b0, '0, 1'b1);
    applyStimulus('0, '0, 1'b1, 1'b1, packW(3, 3, 3, 3), 1'b0);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("t6_lock_sel", 32'(o_sel), 3);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("t6_locked_ready", 32'(o_ready), 32'(4'b1000));
    applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("t6_rst_ready", 32'(o_ready), 0);
    checkOutput("t6_rst_valid", 32'(o_valid), 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("t6_order", 32'(o_sel), 32'(k));
    end

    $display("[TB] randomized traffic against the reference model");
    applyStimulus('0, '0, 1'b1, 1'b0, '0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      rv = 4'($urandom);
      re = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < NI; i++) begin
        rw[i*WBITS +: WBITS] = 4'($urandom_range(0, 4));
      end
      applyStimulus(rv, re, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), rw,
                    ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
